// File: rtl/mem_system_if.sv
// mem_system_if: CPU address/strobe bus and boot-loader byte stream.
interface mem_system_if;
  logic rd;
  logic wr;
  logic [12:0] addr;
  logic ld_valid;
  logic [7:0] ld_data;
  logic ld_last;
  logic ld_ready;
  modport master(output rd, wr, addr, ld_valid, ld_data, ld_last, input ld_ready);
  modport slave(input rd, wr, addr, ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/mem_system.sv
// mem_system: ROM/RAM/GPIO decode for the CPU plus a boot loader that fills ROM before releasing reset.
// Define LOADER_CHECKSUM_EN to treat the final loader byte as a checksum and add an ERROR state.
module mem_system #(
  parameter int ROM_AW = 12,
  parameter int RAM_AW = 8,
  parameter logic [12:0] RAM_BASE = 13'h1800,
  parameter logic [12:0] GPIO_ADDR = 13'h1FFF,
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  mem_system_if.slave bus,
  inout  wire  [7:0] data,
  output logic cpu_rst_n,
  output logic running,
  output logic [7:0] gpio_out,
  output logic bus_err,
  output logic load_ovf
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic load_err
`endif
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {LOAD, HOLD, RUN, ERROR} state_t;
`else
  typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;
`endif
  state_t state, state_nx, load_nx;
  logic [7:0] rom [2**ROM_AW];
  logic [7:0] ram [2**RAM_AW];
  logic [ROM_AW-1:0] ld_ptr;
  logic [7:0] hold_cnt, rdata;
  logic beat, full, rom_we, is_gpio, is_ram, is_rom, run, rd_op, wr_op, err;
  assign run = state == RUN;
  assign running = run;
  assign bus.ld_ready = state == LOAD;
  assign beat = state == LOAD && bus.ld_valid;
  assign full = ld_ptr == '1;
  assign is_gpio = bus.addr == GPIO_ADDR;
  assign is_ram = !is_gpio && bus.addr[12:RAM_AW] == RAM_BASE[12:RAM_AW];
  assign is_rom = !is_gpio && !is_ram && bus.addr[12:ROM_AW] == '0;
  assign rd_op = run && bus.rd && !bus.wr;
  assign wr_op = run && bus.wr && !bus.rd;
  assign err = (run && bus.rd && bus.wr) || (rd_op && !(is_gpio || is_ram || is_rom)) || (wr_op && !(is_gpio || is_ram));
  assign rdata = is_gpio ? gpio_out : is_ram ? ram[bus.addr[RAM_AW-1:0]] : is_rom ? rom[bus.addr[ROM_AW-1:0]] : 8'hFF;
  assign data = rd_op ? rdata : 8'hzz;
`ifdef LOADER_CHECKSUM_EN
  // Running sum of bytes written so far; the ld_last byte must bring it to zero.
  logic [7:0] sum;
  assign rom_we = beat && !bus.ld_last;
  assign load_err = state == ERROR;
  assign load_nx = !beat ? LOAD : bus.ld_last ? (8'(sum + bus.ld_data) == 8'h00 ? HOLD : ERROR) : full ? ERROR : LOAD;
  always_ff @(posedge clk) sum <= rst ? 8'h00 : rom_we ? 8'(sum + bus.ld_data) : sum;
`else
  assign rom_we = beat;
  assign load_nx = beat && (bus.ld_last || full) ? HOLD : LOAD;
`endif
  always_comb begin
    state_nx = state;
    if (state == LOAD) state_nx = load_nx;
    else if (state == HOLD && hold_cnt == 8'(HOLD_CYCLES - 1)) state_nx = RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      ld_ptr <= '0;
      hold_cnt <= 8'd0;
      cpu_rst_n <= 1'b0;
      gpio_out <= 8'h00;
      bus_err <= 1'b0;
      load_ovf <= 1'b0;
    end else begin
      state <= state_nx;
      ld_ptr <= beat ? ld_ptr + 1'b1 : ld_ptr;
      hold_cnt <= state == HOLD ? hold_cnt + 8'd1 : 8'd0;
      cpu_rst_n <= state_nx == RUN;
      bus_err <= err;
      if (beat && full && !bus.ld_last) load_ovf <= 1'b1;
      if (wr_op && is_gpio) gpio_out <= data;
    end
  end
  // Memories keep their contents across reset.
  always_ff @(posedge clk) begin
    if (!rst && rom_we) rom[ld_ptr] <= bus.ld_data;
    if (!rst && wr_op && is_ram) ram[bus.addr[RAM_AW-1:0]] <= data;
  end
endmodule

// File: tb/tb_mem_system.sv
// tb_mem_system: scoreboard bench for mem_system; stimulus queues expectations, a negedge monitor checks them.
module tb_mem_system;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
  logic load_err, load_err2;
`else
  localparam bit CHK = 1'b0;
`endif
  mem_system_if b1();
  mem_system_if b2();
  wire [7:0] data, data2;
  logic [7:0] cpu_d = 8'h00;
  logic cpu_oe = 1'b0;
  assign data = cpu_oe ? cpu_d : 8'hzz;
  logic cpu_rst_n, running, bus_err, load_ovf, cpu_rst_n2, running2, bus_err2, load_ovf2;
  logic [7:0] gpio_out, gpio_out2;
  mem_system dut (
    .clk(clk), .rst(rst), .bus(b1.slave), .data(data), .cpu_rst_n(cpu_rst_n), .running(running),
    .gpio_out(gpio_out), .bus_err(bus_err), .load_ovf(load_ovf)
`ifdef LOADER_CHECKSUM_EN
    , .load_err(load_err)
`endif
  );
  mem_system #(.ROM_AW(4)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave), .data(data2), .cpu_rst_n(cpu_rst_n2), .running(running2),
    .gpio_out(gpio_out2), .bus_err(bus_err2), .load_ovf(load_ovf2)
`ifdef LOADER_CHECKSUM_EN
    , .load_err(load_err2)
`endif
  );
  typedef struct {int due; int sel; logic [7:0] exp; string name;} exp_t;
  exp_t q[$];
  int checks = 0;
  int passes = 0;
  function automatic logic [7:0] obs(int s);
    case (s)
      0: return data;
      1: return gpio_out;
      2: return {7'd0, bus_err};
      3: return {7'd0, cpu_rst_n};
      4: return {7'd0, running};
      5: return {7'd0, b1.ld_ready};
      6: return {7'd0, load_ovf};
      7: return data2;
      8: return {7'd0, load_ovf2};
      9: return {7'd0, running2};
      10: return {7'd0, b2.ld_ready};
`ifdef LOADER_CHECKSUM_EN
      11: return {7'd0, load_err};
`endif
      default: return 8'h00;
    endcase
  endfunction
  always @(negedge clk) begin
    for (int i = 0; i < q.size();) begin
      if (q[i].due <= cyc) begin
        logic [7:0] act;
        act = obs(q[i].sel);
        checks++;
        if (q[i].due == cyc && act === q[i].exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)", q[i].name, act, q[i].exp, cyc, q[i].due);
        q.delete(i);
      end else i++;
    end
  end
  task automatic expect_at(input int d, input int s, input logic [7:0] e, input string n);
    q.push_back('{cyc + d, s, e, n});
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cpu(input logic r, input logic w, input logic [12:0] a, input logic oe, input logic [7:0] d);
    b1.rd = r;
    b1.wr = w;
    b1.addr = a;
    cpu_oe = oe;
    cpu_d = d;
  endtask
  task automatic beat(input bit u, input logic [7:0] d, input bit l);
    if (u) begin
      b2.ld_valid = 1'b1; b2.ld_data = d; b2.ld_last = l;
    end else begin
      b1.ld_valid = 1'b1; b1.ld_data = d; b1.ld_last = l;
    end
    step();
    b1.ld_valid = 1'b0; b1.ld_last = 1'b0;
    b2.ld_valid = 1'b0; b2.ld_last = 1'b0;
  endtask
  logic [7:0] img [16];
  task automatic load(input bit u, input int n, input bit last);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      s = 8'(s + img[i]);
      beat(u, img[i], !CHK && last && i == n - 1);
    end
    if (CHK && last) beat(u, 8'(8'h00 - s), 1'b1);
  endtask
  initial begin
    cpu(0, 0, 13'h0, 0, 8'h00);
    b1.ld_valid = 0; b1.ld_data = 0; b1.ld_last = 0;
    b2.rd = 0; b2.wr = 0; b2.addr = 0; b2.ld_valid = 0; b2.ld_data = 0; b2.ld_last = 0;
    step(2);
    rst = 1'b0;
    #1;
    checks++;
    if (b1.ld_ready === 1'b1) passes++;
    else $display("FAIL ld_ready_direct: got %b", b1.ld_ready);
    expect_at(0, 5, 8'd1, "ld_ready_after_rst");
    expect_at(0, 3, 8'd0, "cpu_rst_n_rst");
    expect_at(0, 4, 8'd0, "running_rst");
    expect_at(0, 1, 8'h00, "gpio_rst");
    expect_at(0, 2, 8'd0, "bus_err_rst");
    expect_at(0, 6, 8'd0, "load_ovf_rst");
    for (int i = 0; i < 16; i++) img[i] = 8'(8'h80 + i);
    load(1'b1, 16, 1'b0);
    expect_at(0, 8, 8'd1, "ovf_sticky");
    expect_at(0, 10, 8'd0, "ovf_ld_ready");
    step(4);
    expect_at(0, 9, CHK ? 8'd0 : 8'd1, "ovf_running");
`ifndef LOADER_CHECKSUM_EN
    b2.rd = 1'b1; b2.addr = 13'h000F;
    expect_at(0, 7, 8'h8F, "ovf_rom15");
    step();
    b2.addr = 13'h0010;
    expect_at(0, 7, 8'hFF, "ovf_beyond_rom");
    step();
    b2.rd = 1'b0;
`endif
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33;
    load(1'b0, 3, 1'b1);
    for (int k = 0; k < 5; k++) expect_at(k, 3, {7'd0, k == 4}, "cpu_rst_n_rise");
    expect_at(0, 5, 8'd0, "ld_ready_hold");
    expect_at(3, 4, 8'd0, "running_hold");
    expect_at(4, 4, 8'd1, "running_run");
    expect_at(4, 6, 8'd0, "no_ovf");
    step(4);
    cpu(1, 0, 13'h0001, 0, 8'h00);
    expect_at(0, 0, 8'h22, "rd_rom1");
    expect_at(1, 2, 8'd0, "rd_rom_no_err");
    step();
    cpu(0, 1, 13'h1805, 1, 8'hA5);
    step();
    cpu(1, 0, 13'h1805, 0, 8'h00);
    expect_at(0, 0, 8'hA5, "rd_ram");
    step();
    cpu(0, 1, 13'h1FFF, 1, 8'h3C);
    expect_at(0, 1, 8'h00, "gpio_before_wr");
    expect_at(1, 1, 8'h3C, "gpio_wr");
    step();
    checks++;
    if (gpio_out === 8'h3C) passes++;
    else $display("FAIL gpio_direct: got %h", gpio_out);
    cpu(1, 0, 13'h1FFF, 0, 8'h00);
    expect_at(0, 0, 8'h3C, "rd_gpio");
    step();
    cpu(0, 1, 13'h0002, 1, 8'h77);
    expect_at(1, 2, 8'd1, "err_wr_rom");
    step();
    cpu(1, 0, 13'h0002, 0, 8'h00);
    expect_at(0, 0, 8'h33, "rom2_kept");
    expect_at(1, 2, 8'd0, "err_pulse_end");
    step();
    cpu(1, 0, 13'h1A00, 0, 8'h00);
    expect_at(0, 0, 8'hFF, "rd_unmapped");
    expect_at(1, 2, 8'd1, "err_rd_unmapped");
    step();
    cpu(0, 1, 13'h1A00, 1, 8'h12);
    expect_at(1, 2, 8'd1, "err_wr_unmapped");
    step();
    cpu(1, 1, 13'h1FFF, 1, 8'h5A);
    expect_at(0, 0, 8'h5A, "rdwr_not_driven");
    expect_at(1, 2, 8'd1, "err_rdwr");
    expect_at(1, 1, 8'h3C, "rdwr_no_gpio_wr");
    step();
    cpu(0, 0, 13'h0, 0, 8'h00);
    expect_at(1, 2, 8'd0, "err_idle");
    b1.ld_valid = 1'b1; b1.ld_data = 8'hEE; b1.ld_last = 1'b1;
    expect_at(0, 5, 8'd0, "ld_ready_run");
    step();
    b1.ld_valid = 1'b0; b1.ld_last = 1'b0;
    cpu(1, 0, 13'h0000, 0, 8'h00);
    expect_at(0, 0, 8'h11, "ld_ignored_rom0");
    expect_at(0, 4, 8'd1, "running_after_ld");
    step();
    cpu(0, 0, 13'h0, 0, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_at(0, 3, 8'd0, "cpu_rst_n_midrun_rst");
    expect_at(0, 1, 8'h00, "gpio_midrun_rst");
    expect_at(0, 4, 8'd0, "running_midrun_rst");
    expect_at(0, 5, 8'd1, "ld_ready_midrun_rst");
    img[0] = 8'hA1; img[1] = 8'hA2;
    load(1'b0, 2, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_at(0, 3, 8'd0, "cpu_rst_n_midload_rst");
    img[0] = 8'h55; img[1] = 8'h66;
    load(1'b0, 2, 1'b1);
    step(4);
    expect_at(0, 4, 8'd1, "running_reload");
    checks++;
    if (running === 1'b1) passes++;
    else $display("FAIL running_reload_direct: got %b", running);
    cpu(1, 0, 13'h0000, 0, 8'h00);
    expect_at(0, 0, 8'h55, "reload_rom0");
    step();
    cpu(1, 0, 13'h0001, 0, 8'h00);
    expect_at(0, 0, 8'h66, "reload_rom1");
    step();
    cpu(1, 0, 13'h0002, 0, 8'h00);
    expect_at(0, 0, 8'h33, "rom2_survives_rst");
    step();
    cpu(0, 0, 13'h0, 0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    beat(1'b0, 8'h10, 1'b0);
    beat(1'b0, 8'h20, 1'b0);
    beat(1'b0, 8'hD0, 1'b1);
    step(4);
    expect_at(0, 4, 8'd1, "chk_ok_running");
    cpu(1, 0, 13'h0001, 0, 8'h00);
    expect_at(0, 0, 8'h20, "chk_ok_rom1");
    step();
    cpu(0, 0, 13'h0, 0, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    beat(1'b0, 8'h10, 1'b0);
    beat(1'b0, 8'h20, 1'b0);
    beat(1'b0, 8'hD1, 1'b1);
    expect_at(0, 11, 8'd1, "chk_bad_load_err");
    expect_at(0, 5, 8'd0, "chk_bad_ld_ready");
    step(6);
    expect_at(0, 3, 8'd0, "chk_bad_cpu_rst_n");
    expect_at(0, 4, 8'd0, "chk_bad_running");
`endif
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    foreach (q[i]) begin
      checks++;
      $display("FAIL %s: never checked, expected %h", q[i].name, q[i].exp);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
